// File: rtl/scandoubler_if.sv
// Pixel/sync bundle for the scandoubler: source video in, doubled video out.
interface scandoubler_if;
  logic       en;
  logic       scanlines;
  logic       ck7;
  logic       ck14;
  logic [2:0] r_in;
  logic [2:0] g_in;
  logic [1:0] b_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;
  logic       hsync;
  logic       vsync;
  logic       csync;

  modport master (
    output en, scanlines, ck7, ck14, r_in, g_in, b_in, hsync_in, vsync_in,
    input  r, g, b, hsync, vsync, csync
  );

  modport slave (
    input  en, scanlines, ck7, ck14, r_in, g_in, b_in, hsync_in, vsync_in,
    output r, g, b, hsync, vsync, csync
  );
endinterface

// File: rtl/scandoubler.sv
// Line-doubling scandoubler: each 7 MHz source line is stored in one bank of a
// two-bank line buffer and replayed twice at 14 MHz from the other bank, with
// optional dimming of every second output line and a registered pass-through.
module scandoubler #(
  parameter int HSYNC_LEN = 54,
  parameter int LINE_MAX  = 512
) (
  input  logic         clk28,
  input  logic         rst,
  scandoubler_if.slave bus
);

  localparam int            AW   = $clog2(LINE_MAX);
  localparam logic [AW-1:0] LAST = AW'(LINE_MAX - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);

  // Source hsync history; a rising edge is seen one clk28 after the input rises.
  logic hs_in_q, hs_in_prev_q;
  logic line_start;
  assign line_start = hs_in_q & ~hs_in_prev_q;

  // Counters and bank select.
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] line_len_q, line_len_d;
  logic          wbank_q, wbank_d;
  logic          odd_line_q, odd_line_d;

  // Line buffer: bank in the MSB of the address, pixel stored as {g,r,b}.
  logic [7:0]  mem_q [2*LINE_MAX];
  logic [AW:0] wr_addr;
  logic [AW:0] rd_addr;
  logic [7:0]  wr_data;

  // Stage 1: buffer read plus everything needed to format that pixel.
  logic [7:0] pix_q;
  logic       dbl_hs_q, blank_q, dim_q, en_q, pt_hs_q, vs_q;
  logic [7:0] pt_pix_q;

  // Stage 2: registered outputs.
  logic [7:0] pix_d;
  logic       hsync_d, vsync_d, csync_d;
  logic [2:0] r_q, g_q;
  logic [1:0] b_q;
  logic       hsync_q, vsync_q, csync_q;

  // A pixel on the edge cycle already belongs to the new line, at address 0 of the new bank.
  assign wr_addr = line_start ? {~wbank_q, {AW{1'b0}}} : {wbank_q, wr_cnt_q};
  assign wr_data = {bus.g_in, bus.r_in, bus.b_in};
  // The read bank is always the one not being written.
  assign rd_addr = {~wbank_q, rd_cnt_q};

  // Register hsync_in twice to find its rising edge.
  always_ff @(posedge clk28 or posedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      hs_in_q      <= 1'b0;
      hs_in_prev_q <= 1'b0;
    end else begin
      hs_in_q      <= bus.hsync_in;
      hs_in_prev_q <= hs_in_q;
    end
  end

  // Write/read counter next-state: line start wins over pixel strobes.
  always_comb begin
    // NOTE: each _d takes its held value first, so no branch can infer a latch.
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    line_len_d = line_len_q;
    wbank_d    = wbank_q;
    odd_line_d = odd_line_q;
    if (line_start) begin
      line_len_d = wr_cnt_q;
      wr_cnt_d   = bus.ck7 ? ONE : '0;
      wbank_d    = ~wbank_q;
      rd_cnt_d   = '0;
      odd_line_d = 1'b0;
    end else begin
      if (bus.ck7 && (wr_cnt_q != LAST)) wr_cnt_d = wr_cnt_q + ONE;
      if (bus.ck14) begin
        if (line_len_q == '0) begin
          rd_cnt_d = '0;
        end else if (rd_cnt_q == line_len_q - ONE) begin
          rd_cnt_d   = '0;
          odd_line_d = ~odd_line_q;
        end else begin
          rd_cnt_d = rd_cnt_q + ONE;
        end
      end
    end
  end

  // Counter and bank registers.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      line_len_q <= '0;
      wbank_q    <= 1'b0;
      odd_line_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      line_len_q <= line_len_d;
      wbank_q    <= wbank_d;
      odd_line_q <= odd_line_d;
    end
  end

  // Line buffer write port.
  always_ff @(posedge clk28) begin
    // NOTE: the buffer has no reset; every address is written before it is read.
    if (bus.ck7) mem_q[wr_addr] <= wr_data;
  end

  // Stage 1: read the buffer and capture the per-pixel controls alongside it.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      pix_q    <= '0;
      dbl_hs_q <= 1'b0;
      blank_q  <= 1'b0;
      dim_q    <= 1'b0;
      en_q     <= 1'b0;
      pt_pix_q <= '0;
      pt_hs_q  <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      pix_q    <= mem_q[rd_addr];
      dbl_hs_q <= (line_len_q != '0) && (int'(rd_cnt_q) < HSYNC_LEN);
      blank_q  <= (line_len_q == '0);
      dim_q    <= bus.scanlines & odd_line_q;
      en_q     <= bus.en;
      pt_pix_q <= wr_data;
      pt_hs_q  <= bus.hsync_in;
      vs_q     <= bus.vsync_in;
    end
  end

  // Stage 2 formatting: blanking, scanline dimming and mode select.
  always_comb begin
    pix_d   = pt_pix_q;
    hsync_d = pt_hs_q;
    if (en_q) begin
      hsync_d = dbl_hs_q;
      if (dbl_hs_q || blank_q)
        pix_d = '0;
      else if (dim_q)
        pix_d = {1'b0, pix_q[7:6], 1'b0, pix_q[4:3], 1'b0, pix_q[1]};
      else
        pix_d = pix_q;
    end
    vsync_d = vs_q;
    csync_d = ~(vsync_d ^ hsync_d);
  end

  // Output registers; composite sync idles high.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      g_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      csync_q <= 1'b1;
    end else begin
      g_q     <= pix_d[7:5];
      r_q     <= pix_d[4:2];
      b_q     <= pix_d[1:0];
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      csync_q <= csync_d;
    end
  end

  assign bus.r     = r_q;
  assign bus.g     = g_q;
  assign bus.b     = b_q;
  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.csync = csync_q;

endmodule

// File: tb/tb_scandoubler.sv
// Self-checking bench for the scandoubler: random source video compared against
// a line-level reference model (stored lines, ck14 counts modulo line length).
module tb_scandoubler;

  localparam int HSYNC_LEN = 54;
  localparam int LINE_MAX  = 512;
  localparam int M_RAMP    = 0;
  localparam int M_CONST   = 1;
  localparam int M_RAND    = 2;

  typedef struct packed {
    logic [7:0] pix;
    logic       hs;
    logic       vs;
  } exp_t;

  logic clk28 = 1'b0;
  logic rst   = 1'b0;

  scandoubler_if bus ();

  scandoubler #(
    .HSYNC_LEN(HSYNC_LEN),
    .LINE_MAX (LINE_MAX)
  ) dut (
    .clk28(clk28),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk28 = ~clk28;

  int n_checks;
  int n_fail;
  int cyc;

  // Reference model state.
  logic       m_h1, m_h2;
  logic [7:0] m_wline [LINE_MAX];
  logic [7:0] m_rline [LINE_MAX];
  int         m_wcount, m_len, m_n14;
  logic       m_edge, m_edge_ck7, m_edge_over;
  logic [7:0] m_last_pix;
  exp_t       exp_d1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Output the DUT should produce two clk28 later for the inputs at this edge.
  function automatic exp_t model_expect();
    exp_t       e;
    int         rd;
    logic       odd;
    logic [7:0] p;
    logic [2:0] gd, rdim;
    logic [1:0] bd;
    e.vs = bus.vsync_in;
    if (!bus.en) begin
      e.pix = {bus.g_in, bus.r_in, bus.b_in};
      e.hs  = bus.hsync_in;
    end else if (m_len == 0) begin
      e.pix = '0;
      e.hs  = 1'b0;
    end else begin
      rd   = m_n14 % m_len;
      odd  = ((m_n14 / m_len) % 2) == 1;
      e.hs = (rd < HSYNC_LEN);
      p    = m_rline[rd];
      gd   = p[7:5] / 3'd2;
      rdim = p[4:2] / 3'd2;
      bd   = p[1:0] / 2'd2;
      if (e.hs)                      e.pix = '0;
      else if (bus.scanlines && odd) e.pix = {gd, rdim, bd};
      else                           e.pix = p;
    end
    return e;
  endfunction

  task automatic model_update();
    logic [7:0] pix;
    pix         = {bus.g_in, bus.r_in, bus.b_in};
    m_edge      = m_h1 && !m_h2;
    m_edge_ck7  = 1'b0;
    m_edge_over = 1'b0;
    if (m_edge) begin
      m_edge_over = (m_wcount >= LINE_MAX);
      m_last_pix  = m_wline[LINE_MAX-1];
      m_rline     = m_wline;
      m_len       = (m_wcount < LINE_MAX - 1) ? m_wcount : LINE_MAX - 1;
      m_n14       = 0;
      m_wcount    = 0;
      if (bus.ck7) begin
        m_wline[0] = pix;
        m_wcount   = 1;
        m_edge_ck7 = 1'b1;
      end
    end else begin
      if (bus.ck7) begin
        m_wline[(m_wcount < LINE_MAX - 1) ? m_wcount : LINE_MAX - 1] = pix;
        m_wcount++;
      end
      if (bus.ck14) m_n14++;
    end
    m_h2 = m_h1;
    m_h1 = bus.hsync_in;
  endtask

  task automatic step();
    exp_t now;
    logic cs;
    @(posedge clk28);
    now = model_expect();
    model_update();
    @(negedge clk28);
    cs = ~(exp_d1.vs ^ exp_d1.hs);
    check("rgb",   {bus.g, bus.r, bus.b}, exp_d1.pix);
    check("hsync", bus.hsync, exp_d1.hs);
    check("vsync", bus.vsync, exp_d1.vs);
    check("csync", bus.csync, cs);
    if (m_edge) begin
      check("line_len", dut.line_len_q, m_len);
      if (m_edge_ck7) check("wr_cnt_edge_ck7", dut.wr_cnt_q, 1);
      if (bus.ck14)   check("rd_cnt_edge_ck14", dut.rd_cnt_q, 0);
      if (m_edge_over)
        check("sat_slot", dut.mem_q[dut.wbank_q ? LINE_MAX - 1 : 2*LINE_MAX - 1], m_last_pix);
    end
    exp_d1 = now;
    cyc++;
  endtask

  task automatic drive(input logic [7:0] pix, input logic hs);
    bus.ck7  = (cyc % 4 == 0);
    bus.ck14 = (cyc % 2 == 0);
    {bus.g_in, bus.r_in, bus.b_in} = pix;
    bus.hsync_in = hs;
    if ($urandom_range(0, 63) == 0) bus.vsync_in = ~bus.vsync_in;
    step();
  endtask

  task automatic pad(input int n);
    for (int i = 0; i < n; i++) drive(8'($urandom), 1'b0);
  endtask

  // One source line: npix ck7 periods, hsync_in high for the first hs_len clk28.
  task automatic run_line(input int npix, input int mode, input int hs_len,
                          input int flip_en_at, input int flip_scan_at);
    int         pcnt;
    logic [7:0] pix;
    pcnt = 0;
    for (int c = 0; c < 4 * npix; c++) begin
      if (c == flip_en_at)   bus.en        = ~bus.en;
      if (c == flip_scan_at) bus.scanlines = ~bus.scanlines;
      pix = 8'($urandom);
      if (cyc % 4 == 0) begin
        if (mode == M_RAMP)       pix = 8'(pcnt);
        else if (mode == M_CONST) pix = 8'hFF;
        pcnt++;
      end
      drive(pix, c < hs_len);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_rgb",   {bus.g, bus.r, bus.b}, 0);
    check("rst_hsync", bus.hsync, 0);
    check("rst_vsync", bus.vsync, 0);
    check("rst_csync", bus.csync, 1);
    repeat (3) @(posedge clk28);
    @(negedge clk28);
    m_h1     = 1'b0;
    m_h2     = 1'b0;
    m_wcount = 0;
    m_len    = 0;
    m_n14    = 0;
    exp_d1   = '0;
    rst      = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit reached");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    exp_d1        = '0;
    bus.en        = 1'b1;
    bus.scanlines = 1'b0;
    bus.ck7       = 1'b0;
    bus.ck14      = 1'b0;
    bus.r_in      = '0;
    bus.g_in      = '0;
    bus.b_in      = '0;
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;
    #2;
    do_reset();

    // Some traffic, then a reset in the middle of a line.
    run_line(120, M_RAND, 16, -1, -1);
    run_line(120, M_RAND, 16, -1, -1);
    pad(150);
    do_reset();

    // First line after reset has no preceding edge: output stays black.
    run_line(448, M_RAMP, 0, -1, -1);
    repeat (3) run_line(448, M_RAMP, 16, -1, -1);

    // Scanline dimming on constant white, then switched off mid-line.
    bus.scanlines = 1'b1;
    repeat (2) run_line(448, M_CONST, 16, -1, -1);
    run_line(448, M_CONST, 16, -1, 1000);
    run_line(448, M_CONST, 16, -1, -1);

    // Overlong lines saturate the write address.
    run_line(600, M_RAMP, 16, -1, -1);
    run_line(600, M_RAND, 16, -1, -1);
    run_line(200, M_RAND, 16, -1, -1);

    // Line start landing on both a ck7 and a ck14.
    while ((cyc + 1) % 4 != 0) pad(1);
    run_line(100, M_RAMP, 16, -1, -1);
    run_line(100, M_RAND, 16, -1, -1);

    // Pass-through, with mode switches in the middle of lines.
    bus.en = 1'b0;
    run_line(200, M_RAND, 16, 301, -1);
    run_line(200, M_RAND, 16, 517, -1);
    bus.en = 1'b1;

    // Random line lengths, phases and control flips.
    for (int i = 0; i < 14; i++) begin
      pad($urandom_range(0, 3));
      bus.scanlines = 1'($urandom_range(0, 1));
      run_line($urandom_range(1, 300), M_RAND, $urandom_range(2, 40),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 400) : -1,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 400) : -1);
    end
    run_line(64, M_RAND, 16, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
